// File: rtl/dmem_byte_sequencer_pkg.sv
// Shared types and helpers for the byte-wide data memory sequencer.
// Holds the access-size and FSM state encodings and the memory depth.
package dmem_pkg;

    localparam int unsigned DMEM_DEPTH = 32;

    typedef enum logic [1:0] {
        B = 2'd0,
        H = 2'd1,
        W = 2'd2,
        D = 2'd3
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [3:0] size_bytes(input size_t s);
        logic [3:0] n;
        unique case (s)
            B:       n = 4'd1;
            H:       n = 4'd2;
            W:       n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_byte_sequencer_if.sv
// MEM-stage request/response bundle between the pipeline and the sequencer.
// The pipeline side is the master; the sequencer is the slave.
interface dmem_byte_sequencer_if;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic        rsp_err;
    logic [63:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  stall, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output stall, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/dmem_byte_sequencer_load_extend.sv
// Sign/zero extension of a little-endian load buffer to 64 bits.
// Upper bytes take the top loaded bit when signed, otherwise zero.
module dmem_load_extend
    import dmem_pkg::*;
(
    input  logic [63:0] rbuf_i,
    input  size_t       size_i,
    input  logic        signed_i,
    output logic [63:0] data_o
);

    always_comb begin
        data_o = rbuf_i;
        unique case (size_i)
            B:       data_o = {{56{signed_i & rbuf_i[7]}},  rbuf_i[7:0]};
            H:       data_o = {{48{signed_i & rbuf_i[15]}}, rbuf_i[15:0]};
            W:       data_o = {{32{signed_i & rbuf_i[31]}}, rbuf_i[31:0]};
            default: data_o = rbuf_i;
        endcase
    end

endmodule

// File: rtl/dmem_byte_sequencer.sv
// Splits a 1/2/4/8-byte load/store into single-byte memory accesses,
// stalling the pipeline until the little-endian response is ready.
module dmem_byte_sequencer
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = DMEM_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_byte_sequencer_if.slave  bus,
    output logic [63:0]           mem_adr,
    output logic [7:0]            mem_din,
    output logic                  mem_w,
    output logic                  mem_r,
    input  logic [7:0]            mem_dout
);

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    size_t       size_q, size_d;
    logic        we_q, we_d;
    logic        signed_q, signed_d;
    logic        err_q, err_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rbuf_q, rbuf_d;

    logic [3:0]  req_n;
    logic [3:0]  cur_n;
    logic [64:0] end_sum;
    logic        range_err;
    logic [63:0] ext_data;

    logic        stall;
    logic        rsp_valid;
    logic        rsp_err;
    logic [63:0] rsp_rdata;

    dmem_load_extend u_ext (
        .rbuf_i   (rbuf_q),
        .size_i   (size_q),
        .signed_i (signed_q),
        .data_o   (ext_data)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        size_d    = size_q;
        we_d      = we_q;
        signed_d  = signed_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rbuf_d    = rbuf_q;

        stall     = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        mem_adr   = '0;
        mem_din   = '0;
        mem_w     = 1'b0;
        mem_r     = 1'b0;

        req_n     = size_bytes(size_t'(bus.req_size));
        cur_n     = size_bytes(size_q);
        // 65-bit sum so addresses near 2^64 cannot wrap into range
        end_sum   = {1'b0, bus.req_addr} + {61'd0, req_n};
        range_err = end_sum > 65'(DEPTH);

        unique case (state_q)
            IDLE: begin
                stall = bus.req_valid;
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    signed_d = bus.req_signed;
                    size_d   = size_t'(bus.req_size);
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    idx_d    = '0;
                    rbuf_d   = '0;
                    err_d    = range_err;
                    state_d  = range_err ? DONE : XFER;
                end
            end
            XFER: begin
                stall   = 1'b1;
                mem_adr = addr_q + {61'd0, idx_q};
                if (we_q) begin
                    mem_w   = 1'b1;
                    mem_din = wdata_q[{idx_q, 3'b000} +: 8];
                end else begin
                    mem_r = 1'b1;
                    rbuf_d[{idx_q, 3'b000} +: 8] = mem_dout;
                end
                if ({1'b0, idx_q} == cur_n - 4'd1) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (we_q || err_q) ? '0 : ext_data;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            size_q   <= B;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rbuf_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            size_q   <= size_d;
            we_q     <= we_d;
            signed_q <= signed_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rbuf_q   <= rbuf_d;
        end
    end

    assign bus.stall     = stall;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_err   = rsp_err;
    assign bus.rsp_rdata = rsp_rdata;

endmodule

// File: tb/tb_dmem_byte_sequencer.sv
// Scoreboard bench for dmem_byte_sequencer: directed cases plus random traffic
// against an array-based reference of the byte memory.
module tb_dmem_byte_sequencer;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_clear;
    logic [63:0] mem_adr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        mem_w;
    logic        mem_r;

    always #5 clk = ~clk;

    dmem_byte_sequencer_if bus ();

    dmem_byte_sequencer #(.DEPTH(DMEM_DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .mem_adr  (mem_adr),
        .mem_din  (mem_din),
        .mem_w    (mem_w),
        .mem_r    (mem_r),
        .mem_dout (mem_dout)
    );

    // Physical memory seen by the DUT
    logic [7:0] mem_arr [32];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 32; i++) mem_arr[i] <= 8'h00;
        end else if (mem_w && mem_adr < 64'd32) begin
            mem_arr[mem_adr[4:0]] <= mem_din;
        end
    end
    assign mem_dout = (mem_adr < 64'd32) ? mem_arr[mem_adr[4:0]] : 8'h00;

    // Reference model: what memory should hold after each accepted request
    logic [7:0] ref_mem [32];

    typedef struct {
        logic        err;
        logic [63:0] rdata;
        int unsigned stalls;
        int unsigned wr;
        int unsigned rd;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    int unsigned n_timeouts = 0;
    logic        done = 1'b0;

    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [63:0] addr, input logic [63:0] wd);
        int unsigned n;
        exp_t        e;
        logic [63:0] v;
        logic        got;
        n = 1 << sz;
        e.err    = (addr >= 64'd32) || (64'(n) > 64'd32 - addr);
        e.rdata  = '0;
        e.stalls = e.err ? 1 : n + 1;
        e.wr     = (!e.err && we)  ? n : 0;
        e.rd     = (!e.err && !we) ? n : 0;
        if (!e.err) begin
            if (we) begin
                for (int i = 0; i < int'(n); i++) ref_mem[addr[4:0] + 5'(i)] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < int'(n); i++) v = v | (64'(ref_mem[addr[4:0] + 5'(i)]) << (8*i));
                if (sg && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
                e.rdata = v;
            end
        end
        sb.push_back(e);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) got = 1'b1;
        end
        if (!got) n_timeouts++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Stimulus
    initial begin
        logic [63:0] a;
        reset          = 1'b1;
        mem_clear      = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_clear = 1'b0;
        idle_cycle();

        do_req(1'b1, 2'd3, 1'b0, 64'd0, 64'h1122334455667788);
        do_req(1'b0, 2'd3, 1'b0, 64'd0, 64'd0);
        idle_cycle();
        do_req(1'b1, 2'd0, 1'b0, 64'd5, 64'h80);
        do_req(1'b0, 2'd0, 1'b1, 64'd5, 64'd0);
        do_req(1'b0, 2'd0, 1'b0, 64'd5, 64'd0);
        do_req(1'b1, 2'd0, 1'b0, 64'd4, 64'h01);
        do_req(1'b0, 2'd1, 1'b1, 64'd4, 64'd0);
        idle_cycle();
        do_req(1'b0, 2'd2, 1'b0, 64'd28, 64'd0);
        do_req(1'b0, 2'd2, 1'b0, 64'd29, 64'd0);
        do_req(1'b1, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hDEAD_BEEF_0000_0001);
        idle_cycle();
        do_req(1'b1, 2'd3, 1'b0, 64'd8, 64'hCAFE_F00D_0BAD_BEEF);
        do_req(1'b0, 2'd3, 1'b0, 64'd8, 64'd0);
        idle_cycle();

        // Reset in the third XFER cycle of an 8-byte store to addr 16
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_size   = 2'd3;
        bus.req_signed = 1'b0;
        bus.req_addr   = 64'd16;
        bus.req_wdata  = 64'hA8A7A6A5A4A3A2A1;
        repeat (3) @(posedge clk);
        #1;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ref_mem[16] = 8'hA1;
        ref_mem[17] = 8'hA2;
        ref_mem[18] = 8'hA3;
        idle_cycle();
        do_req(1'b0, 2'd3, 1'b0, 64'd16, 64'd0);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) == 0) a = {$urandom, $urandom};
            else a = 64'($urandom_range(0, 35));
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   a, {$urandom, $urandom});
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();
        idle_cycle();
        done = 1'b1;
    end

    // Monitor and scoreboard
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int unsigned stall_cnt = 0;
        int unsigned wr_cnt    = 0;
        int unsigned rd_cnt    = 0;
        logic        rst_seen  = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_cnt = 0;
                wr_cnt    = 0;
                rd_cnt    = 0;
                rst_seen  = 1'b1;
            end else begin
                if (rst_seen) begin
                    chk("rst_stall",     64'(bus.stall),     64'd0);
                    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
                    chk("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
                    chk("rst_rsp_rdata", bus.rsp_rdata,      64'd0);
                    chk("rst_mem_w",     64'(mem_w),         64'd0);
                    chk("rst_mem_r",     64'(mem_r),         64'd0);
                    chk("rst_mem_adr",   mem_adr,            64'd0);
                    chk("rst_mem_din",   64'(mem_din),       64'd0);
                    rst_seen = 1'b0;
                end
                if (bus.stall) stall_cnt++;
                if (mem_w) wr_cnt++;
                if (mem_r) rd_cnt++;
                if (mem_w || mem_r) begin
                    chk("strobe_excl", 64'(mem_w & mem_r), 64'd0);
                    chk("adr_in_range", 64'(mem_adr < 64'd32), 64'd1);
                end else if (mem_adr != 64'd0 || mem_din != 8'd0) begin
                    chk("idle_mem_bus", {mem_adr[55:0], mem_din}, 64'd0);
                end
                if (bus.rsp_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_rsp", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_err",    64'(bus.rsp_err), 64'(e.err));
                        chk("rsp_rdata",  bus.rsp_rdata,    e.rdata);
                        chk("stall_cyc",  64'(stall_cnt),   64'(e.stalls));
                        chk("wr_strobes", 64'(wr_cnt),      64'(e.wr));
                        chk("rd_strobes", 64'(rd_cnt),      64'(e.rd));
                    end
                    stall_cnt = 0;
                    wr_cnt    = 0;
                    rd_cnt    = 0;
                end
                if (done) begin
                    chk("pending_rsp", 64'(sb.size()), 64'd0);
                    chk("timeouts",    64'(n_timeouts), 64'd0);
                    for (int i = 0; i < 32; i++) chk("final_mem", 64'(mem_arr[i]), 64'(ref_mem[i]));
                    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
                    $finish;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_byte_sequencer.md
# dmem_byte_sequencer

Sequencer between the pipeline MEM stage and the byte-wide data memory (8-bit cells, 32 entries). It turns one load/store request of 1, 2, 4 or 8 bytes into a run of single-byte memory accesses, stalls the pipeline while the run is in progress, and returns a little-endian, optionally sign-extended 64-bit load result. Requests whose last byte lies beyond the memory are rejected with an error instead of touching memory.

## Interface
- `DEPTH`, 32: number of bytes in the data memory; valid byte addresses are 0..DEPTH-1.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: MEM-stage access request; the pipeline holds all `req_*` stable while `stall`=1.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = 8 bytes.
- `req_signed`  in  1: loads only; sign-extend the result from the top loaded byte.
- `req_addr`  in  64: byte address of the lowest byte.
- `req_wdata`  in  64: store data; byte i is `req_wdata[8i+7:8i]`.
- `stall`  out  1: freezes the pipeline.
- `rsp_valid`  out  1: one-cycle completion pulse.
- `rsp_err`  out  1: qualifies `rsp_valid`; the range check failed.
- `rsp_rdata`  out  64: load result, valid while `rsp_valid`=1; 0 for stores and errors.
- `mem_adr`  out  64: byte address to memory.
- `mem_din`  out  8: write byte.
- `mem_w`  out  1: write strobe; memory writes on the rising edge.
- `mem_r`  out  1: read enable; memory read is combinational.
- `mem_dout`  in  8: read byte.

## Operation
- States: IDLE, XFER, DONE.
- IDLE:
  - If `req_valid`=1, latch we, signed, base address, byte count N (1/2/4/8) and wdata; clear byte index and the read buffer.
  - Range check uses a 65-bit sum: `req_addr + N > DEPTH` gives an error. On error, go to DONE with the error flag set; otherwise go to XFER.
  - If `req_valid`=0, stay in IDLE.
- XFER, byte index i from 0 to N-1, one byte per cycle:
  - `mem_adr` = base + i.
  - Store: `mem_w`=1, `mem_r`=0, `mem_din` = wdata byte i.
  - Load: `mem_r`=1, `mem_w`=0; `mem_dout` is captured into read-buffer byte i at the clock edge.
  - After byte N-1, go to DONE.
- DONE:
  - `rsp_valid`=1 and `rsp_err` = error flag.
  - `rsp_rdata` = read buffer. For a load with `req_signed`=1 and N<8, the upper bytes are filled with bit 8N-1 of the buffer; otherwise they are zero-filled. It is 0 on a store or an error.
  - Always returns to IDLE. `req_valid` is ignored in DONE.
- Memory strobes are 0, and `mem_adr`/`mem_din` are 0, in every state other than XFER. An error request never drives a strobe.
- `stall` = (IDLE and `req_valid`) or XFER. `stall` is 0 in DONE, so the pipeline advances on the same edge that returns the block to IDLE.
- Reset, including mid-XFER: go to IDLE; all outputs 0; internal registers cleared. Bytes already written stay in memory (no rollback).

## Timing
- The request is accepted at edge 0. XFER covers cycles 1..N. DONE is at cycle N+1, so latency from the accept cycle to `rsp_valid` is N+1 cycles.
- Total `stall` cycles per request: N+1 (1 byte: 2, 8 bytes: 9).
- Error path: accept cycle, then DONE; 1 stall cycle.
- Back-to-back requests: the next request can be accepted in the cycle immediately after DONE. Sustained rate for 8-byte accesses is one every 10 cycles.
- `rsp_valid` and `rsp_err` are decoded from the state register and are glitch-free relative to `clk`.

## Structure
- Package `dmem_pkg` holds:
  - the `size_t` enum (B, H, W, D);
  - the `state_t` enum (IDLE, XFER, DONE);
  - `function size_bytes(size_t)` returning 1/2/4/8;
  - constant `DMEM_DEPTH` = 32.
- One sub-module, `dmem_load_extend`: combinational sign/zero extension of the read buffer by N and signed. It is reused by any other load path.
- The rest of the block (FSM, index counter, latches, read buffer) lives in `dmem_byte_sequencer`.

## Test plan
- 8-byte store to addr 0 with `0x1122334455667788` -> `mem_w` pulses 8 cycles, bytes 88,77,…,11 land at 0..7; `stall` high 9 cycles; `rsp_valid` with `rsp_rdata`=0.
- 8-byte load from addr 0 after the previous store -> `rsp_rdata`=`0x1122334455667788` at cycle 9; `mem_r` high cycles 1..8 only.
- Pre-load byte 0x80 at addr 5: 1-byte signed load -> `0xFFFFFFFFFFFFFF80`; unsigned -> `0x80`. 2-byte signed load at addr 4 with bytes {0x01,0x80} -> `0xFFFFFFFFFFFF8001`.
- Range boundaries:
  - 4-byte load at addr 28 -> OK, 5 stall cycles.
  - 4-byte load at addr 29 -> `rsp_err`=1 one cycle after accept, `mem_r`/`mem_w` never asserted.
  - Addr `0xFFFFFFFFFFFFFFFC` size 3 -> `rsp_err`=1 (no wrap).
- Back-to-back store addr 8, then load addr 8 (8 bytes each, `req_valid` held continuously) -> second accept in the cycle after the first DONE; load returns the stored value.
- `reset` asserted in XFER cycle 3 of an 8-byte store -> next cycle IDLE, all outputs 0, only bytes 0..2 written; a following request runs normally.
